// File: rtl/pe_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pe_job_arbiter
// Description : Round-robin sharing of one processing element between
//               NUM_REQ requesters, with a result-wait watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_input,
  input  logic [NUM_REQ*16-1:0]   req_weight,
  input  logic [NUM_REQ*2-1:0]    req_act_type,
  output logic [15:0]             pe_input_data,
  output logic [15:0]             pe_weight_data,
  output logic                    pe_input_valid,
  output logic                    pe_weight_valid,
  input  logic                    pe_input_ready,
  input  logic                    pe_weight_ready,
  output logic [1:0]              pe_act_type,
  input  logic [39:0]             pe_output_data,
  input  logic                    pe_output_valid,
  output logic                    pe_output_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [39:0]             rsp_data,
  output logic                    rsp_error,
  output logic                    busy,
  output logic [15:0]             timeout_count
);

  localparam int c_tmr_w = $clog2(TIMEOUT);
  localparam logic [c_tmr_w-1:0] c_tmo_last = c_tmr_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_id;
  logic [15:0]          r_input;
  logic [15:0]          r_weight;
  logic [1:0]           r_act;
  logic [c_tmr_w-1:0]   r_timer;
  logic [39:0]          r_rsp_data;
  logic                 r_rsp_error;
  logic [15:0]          r_tcount;

  logic                 w_found;
  logic [ID_W-1:0]      w_gnt;

  // Requester index base+off taken modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_gnt   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // Gated by rst_n so no accept is ever signalled while reset is held.
  assign req_ready = (rst_n && (r_state == S_IDLE) && w_found) ? (NUM_REQ'(1) << w_gnt) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_input     <= '0;
      r_weight    <= '0;
      r_act       <= '0;
      r_timer     <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_tcount    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id     <= w_gnt;
            r_input  <= req_input[16*w_gnt +: 16];
            r_weight <= req_weight[16*w_gnt +: 16];
            r_act    <= req_act_type[2*w_gnt +: 2];
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pe_input_ready && pe_weight_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A result arriving on the final watchdog cycle still wins.
          if (pe_output_valid) begin
            r_rsp_data  <= pe_output_data;
            r_rsp_error <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_timer == c_tmo_last) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
            if (r_tcount != 16'hFFFF) r_tcount <= r_tcount + 16'd1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + c_tmr_w'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rr_ptr <= wrap_add(r_id, 1);
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pe_input_valid  = (r_state == S_ISSUE);
  assign pe_weight_valid = (r_state == S_ISSUE);
  assign pe_input_data   = (r_state == S_ISSUE) ? r_input  : 16'd0;
  assign pe_weight_data  = (r_state == S_ISSUE) ? r_weight : 16'd0;
  assign pe_act_type     = (r_state != S_IDLE)  ? r_act    : 2'd0;
  assign pe_output_ready = (r_state == S_WAIT);
  assign rsp_valid       = (r_state == S_RESP);
  assign rsp_id          = r_id;
  assign rsp_data        = r_rsp_data;
  assign rsp_error       = r_rsp_error;
  assign busy            = (r_state != S_IDLE);
  assign timeout_count   = r_tcount;

endmodule
`default_nettype wire

// File: tb/tb_pe_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_job_arbiter
// Description : Directed/random bench for pe_job_arbiter with a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_job_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_input;
  logic [NUM_REQ*16-1:0] req_weight;
  logic [NUM_REQ*2-1:0]  req_act_type;
  logic [15:0]           pe_input_data;
  logic [15:0]           pe_weight_data;
  logic                  pe_input_valid;
  logic                  pe_weight_valid;
  logic                  pe_input_ready;
  logic                  pe_weight_ready;
  logic [1:0]            pe_act_type;
  logic [39:0]           pe_output_data;
  logic                  pe_output_valid;
  logic                  pe_output_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [39:0]           rsp_data;
  logic                  rsp_error;
  logic                  busy;
  logic [15:0]           timeout_count;

  int n_assert = 0;
  int n_fail   = 0;
  int m_rr     = 0;
  int m_tc     = 0;

  always #5 clk = ~clk;

  pe_job_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_input(req_input), .req_weight(req_weight), .req_act_type(req_act_type),
    .pe_input_data(pe_input_data), .pe_weight_data(pe_weight_data),
    .pe_input_valid(pe_input_valid), .pe_weight_valid(pe_weight_valid),
    .pe_input_ready(pe_input_ready), .pe_weight_ready(pe_weight_ready),
    .pe_act_type(pe_act_type),
    .pe_output_data(pe_output_data), .pe_output_valid(pe_output_valid),
    .pe_output_ready(pe_output_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy), .timeout_count(timeout_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Next winner: first valid requester at or after the round-robin pointer.
  function automatic int pick(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic rand_ops;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_input[16*i +: 16]  = 16'($urandom);
      req_weight[16*i +: 16] = 16'($urandom);
      req_act_type[2*i +: 2] = 2'($urandom);
    end
  endtask

  // One complete job from grant to response handshake.
  task automatic run_job(input int stall, input int delay, input bit to,
                         input int rhold, input logic [39:0] res);
    int id;
    int cnt;
    int guard;
    logic [15:0] ei, ew;
    logic [1:0] ea;
    logic [39:0] edata;
    logic [NUM_REQ-1:0] saved;
    #1;
    id = pick(req_valid);
    if (id < 0) id = 0;
    ei = req_input[16*id +: 16];
    ew = req_weight[16*id +: 16];
    ea = req_act_type[2*id +: 2];
    chk("grant_ready", 64'(req_ready), 64'(1) << id);
    chk("busy_idle", 64'(busy), 64'd0);
    tick;
    saved = req_valid;
    req_valid = NUM_REQ'($urandom);
    for (int s = 0; s < stall; s++) begin
      {pe_input_ready, pe_weight_ready} = 2'($urandom_range(0, 2));
      pe_output_valid = 1'($urandom);
      #1;
      chk("issue_valid", 64'({pe_input_valid, pe_weight_valid}), 64'd3);
      chk("issue_data", 64'({pe_input_data, pe_weight_data}), 64'({ei, ew}));
      chk("issue_act", 64'(pe_act_type), 64'(ea));
      tick;
    end
    pe_output_valid = 1'b0;
    pe_input_ready  = 1'b1;
    pe_weight_ready = 1'b1;
    #1;
    chk("xfer_data", 64'({pe_input_valid, pe_input_data, pe_weight_data}), 64'({1'b1, ei, ew}));
    tick;
    pe_input_ready  = 1'b0;
    pe_weight_ready = 1'b0;
    if (to) begin
      cnt = 0;
      guard = 0;
      while (rsp_valid !== 1'b1 && guard < 4 * TIMEOUT) begin
        if (pe_output_ready === 1'b1) cnt++;
        guard++;
        tick;
      end
      chk("wait_cycles", 64'(cnt), 64'(TIMEOUT));
      edata = '0;
      if (m_tc < 65535) m_tc++;
    end else begin
      for (int d = 0; d < delay; d++) begin
        chk("no_early_rsp", 64'({rsp_valid, pe_output_ready}), 64'b01);
        tick;
      end
      pe_output_data  = res;
      pe_output_valid = 1'b1;
      tick;
      pe_output_valid = 1'b0;
      pe_output_data  = 40'($urandom);
      edata = res;
    end
    for (int h = 0; h < rhold; h++) begin
      chk("rsp_hold", 64'({rsp_valid, rsp_error, rsp_id}), 64'({1'b1, to, ID_W'(id)}));
      chk("rsp_hold_data", 64'(rsp_data), 64'(edata));
      chk("no_grant_in_resp", 64'({req_ready, busy}), 64'd1);
      pe_output_valid = 1'($urandom);
      pe_output_data  = 40'($urandom);
      tick;
    end
    pe_output_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rsp_fields", 64'({rsp_valid, rsp_error, rsp_id}), 64'({1'b1, to, ID_W'(id)}));
    chk("rsp_data", 64'(rsp_data), 64'(edata));
    chk("rsp_act", 64'(pe_act_type), 64'(ea));
    chk("timeout_count", 64'(timeout_count), 64'(m_tc));
    tick;
    rsp_ready = 1'b0;
    m_rr = (id + 1) % NUM_REQ;
    req_valid = saved;
    chk("idle_after_rsp", 64'({busy, rsp_valid, pe_act_type}), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({req_ready, pe_input_valid, pe_weight_valid, pe_output_ready,
                  rsp_valid, rsp_error, rsp_id, busy, pe_act_type}), 64'd0);
    chk({tag, "_data"}, 64'({pe_input_data, pe_weight_data}), 64'd0);
    chk({tag, "_rsp"}, 64'(rsp_data), 64'd0);
    chk({tag, "_tcount"}, 64'(timeout_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, d, rh;
    bit to;
    rst_n = 1'b0;
    req_valid = '1;
    req_input = '0;
    req_weight = '0;
    req_act_type = '0;
    pe_input_ready = 1'b0;
    pe_weight_ready = 1'b0;
    pe_output_data = '0;
    pe_output_valid = 1'b0;
    rsp_ready = 1'b0;
    tick;
    tick;
    chk_all_zero("reset");
    req_valid = '0;
    rst_n = 1'b1;
    tick;
    chk("idle_no_req", 64'({req_ready, busy}), 64'd0);

    // Single job from requester 2
    req_input[16*2 +: 16]  = 16'h0003;
    req_weight[16*2 +: 16] = 16'h0004;
    req_act_type[2*2 +: 2] = 2'd0;
    req_valid = 4'b0100;
    run_job(0, 0, 1'b0, 0, 40'h000000000C);

    // Pointer now 3: response backpressure on job 3, then wrap to 0
    rand_ops;
    req_valid = 4'b1011;
    run_job(0, 2, 1'b0, 10, 40'($urandom));
    req_valid = 4'b0011;
    run_job(0, 1, 1'b0, 0, 40'($urandom));

    // PE input backpressure
    rand_ops;
    req_valid = 4'b1111;
    run_job(5, 0, 1'b0, 0, 40'($urandom));

    // Timeout, then a normal job
    rand_ops;
    run_job(0, 0, 1'b1, 0, 40'd0);
    run_job(1, 3, 1'b0, 1, 40'($urandom));

    // Result on the last watchdog cycle wins
    run_job(0, TIMEOUT - 1, 1'b0, 0, 40'($urandom));

    // Fairness: everyone requesting
    req_valid = '1;
    for (int j = 0; j < 8; j++) begin
      rand_ops;
      run_job(0, 0, 1'b0, 0, 40'($urandom));
    end

    // Random jobs
    for (int j = 0; j < 12; j++) begin
      rand_ops;
      req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      s  = $urandom_range(0, 3);
      rh = $urandom_range(0, 3);
      to = ($urandom_range(0, 5) == 0);
      d  = $urandom_range(0, 8);
      run_job(s, d, to, rh, 40'({$urandom, $urandom}));
    end

    // Reset while waiting for a result
    rand_ops;
    req_valid = '1;
    tick;
    pe_input_ready = 1'b1;
    pe_weight_ready = 1'b1;
    tick;
    pe_input_ready = 1'b0;
    pe_weight_ready = 1'b0;
    tick;
    chk("pre_reset_wait", 64'({pe_output_ready, rsp_valid}), 64'b10);
    rst_n = 1'b0;
    tick;
    chk_all_zero("mid_reset");
    m_rr = 0;
    m_tc = 0;
    rst_n = 1'b1;
    req_valid = '0;
    pe_output_valid = 1'b1;
    pe_output_data = 40'hFF_FFFF_FFFF;
    tick;
    chk("no_rsp_after_reset", 64'({rsp_valid, busy}), 64'd0);
    pe_output_valid = 1'b0;
    rand_ops;
    req_valid = 4'b1010;
    run_job(0, 0, 1'b0, 0, 40'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
